// File: rtl/morse_pkg.sv
// Shared types and the Morse digit code table for the digit decoder.
// Patterns are five symbols, with the first symbol sent held in bit 4.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    GAP   = 2'd2,
    EMIT  = 2'd3
  } state_t;

  localparam logic DOT  = 1'b0;
  localparam logic DASH = 1'b1;

  localparam logic [4:0] CODE_1 = 5'b01111;
  localparam logic [4:0] CODE_2 = 5'b00111;
  localparam logic [4:0] CODE_3 = 5'b00011;
  localparam logic [4:0] CODE_4 = 5'b00001;
  localparam logic [4:0] CODE_5 = 5'b00000;
  localparam logic [4:0] CODE_6 = 5'b10000;
  localparam logic [4:0] CODE_7 = 5'b11000;
  localparam logic [4:0] CODE_8 = 5'b11100;
  localparam logic [4:0] CODE_9 = 5'b11110;
  localparam logic [4:0] CODE_0 = 5'b11111;

  typedef struct packed {
    logic       valid;
    logic [3:0] digit;
  } decode_t;

  function automatic decode_t decode(input logic [4:0] sym);
    decode_t r;
    r.valid = 1'b1;
    r.digit = 4'd0;
    case (sym)
      CODE_0:  r.digit = 4'd0;
      CODE_1:  r.digit = 4'd1;
      CODE_2:  r.digit = 4'd2;
      CODE_3:  r.digit = 4'd3;
      CODE_4:  r.digit = 4'd4;
      CODE_5:  r.digit = 4'd5;
      CODE_6:  r.digit = 4'd6;
      CODE_7:  r.digit = 4'd7;
      CODE_8:  r.digit = 4'd8;
      CODE_9:  r.digit = 4'd9;
      default: r.valid = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/morse_debounce.sv
// Two-flop synchroniser followed by a stable-level debouncer for the Morse key.
// key_db follows the synchronised key once it has differed for DEBOUNCE_CYC cycles.
module morse_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int CNT_W        = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic key_db
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             key_p0;
  logic             key_p1;
  logic [CNT_W-1:0] stable_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_p0     <= 1'b0;
      key_p1     <= 1'b0;
      key_db     <= 1'b0;
      stable_cnt <= '0;
    end else begin
      key_p0 <= key;
      key_p1 <= key_p0;
      // Any return to the current debounced level restarts the stability window.
      if (key_p1 == key_db) begin
        stable_cnt <= '0;
      end else if (stable_cnt == STABLE_LAST) begin
        key_db     <= key_p1;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/morse_digit_decoder.sv
// Morse key front end: debounces the key, classifies dots/dashes, emits digits 0-9.
// Optional macro MORSE_ERR_EN enables the err pulse on invalid patterns.
module morse_digit_decoder
  import morse_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int DASH_CYC     = 30_000_000,
  parameter int GAP_CYC      = 60_000_000,
  parameter int CNT_W        = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key,
  output logic [3:0] digit,
  output logic       flag,
  output logic       err
);

  localparam logic [CNT_W-1:0] DASH_LIM = CNT_W'(DASH_CYC);
  // Decision is registered on the edge where the gap counter reaches GAP_CYC-1,
  // so flag/err rise exactly GAP_CYC cycles after the key_db fall.
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 2);

  logic             key_db;
  logic             key_db_q;
  logic             rise;
  logic             fall;
  logic             ok;
  decode_t          dec;
  state_t           state;
  logic [CNT_W-1:0] press_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic [4:0]       sym;
  logic [2:0]       n;
  logic             ovf;

  morse_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .CNT_W       (CNT_W)
  ) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .key   (key),
    .key_db(key_db)
  );

  assign rise = key_db & ~key_db_q;
  assign fall = ~key_db & key_db_q;
  assign dec  = decode(sym);
  assign ok   = (n == 3'd5) && !ovf && dec.valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_db_q  <= 1'b0;
      state     <= IDLE;
      press_cnt <= '0;
      gap_cnt   <= '0;
      sym       <= '0;
      n         <= '0;
      ovf       <= 1'b0;
      digit     <= 4'd0;
      flag      <= 1'b0;
      err       <= 1'b0;
    end else begin
      key_db_q <= key_db;
      flag     <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state     <= PRESS;
            press_cnt <= '0;
          end
        end
        PRESS: begin
          if (fall) begin
            if (n == 3'd5) begin
              ovf <= 1'b1;
            end else begin
              sym <= {sym[3:0], (press_cnt >= DASH_LIM) ? DASH : DOT};
              n   <= n + 3'd1;
            end
            gap_cnt <= '0;
            state   <= GAP;
          end else if (press_cnt != DASH_LIM) begin
            press_cnt <= press_cnt + 1'b1;
          end
        end
        GAP: begin
          if (rise) begin
            state     <= PRESS;
            press_cnt <= '0;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
            if (gap_cnt == GAP_LAST) begin
              state <= EMIT;
              if (ok) begin
                digit <= dec.digit;
                flag  <= 1'b1;
              end
`ifdef MORSE_ERR_EN
              else begin
                err <= 1'b1;
              end
`endif
            end
          end
        end
        EMIT: begin
          sym <= '0;
          n   <= '0;
          ovf <= 1'b0;
          if (rise) begin
            state     <= PRESS;
            press_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_digit_decoder.sv
// Table-driven bench for morse_digit_decoder with a pulse scoreboard.
module tb_morse_digit_decoder;

  localparam int DB   = 4;
  localparam int DASH = 20;
  localparam int GAP  = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key = 1'b0;
  logic [3:0] digit;
  logic       flag;
  logic       err;

  morse_digit_decoder #(
    .DEBOUNCE_CYC(DB),
    .DASH_CYC    (DASH),
    .GAP_CYC     (GAP),
    .CNT_W       (16)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .key  (key),
    .digit(digit),
    .flag (flag),
    .err  (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      pat;
    bit         glitch;
    bit         valid;
    logic [3:0] dig;
  } vec_t;

  typedef struct {
    bit         is_flag;
    logic [3:0] dig;
  } exp_t;

  vec_t       vecs[11];
  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         last_fall = 0;
  bit         prev_db = 1'b0;
  bit         err_en;
  logic [3:0] model_digit = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic press(input int len);
    key = 1'b1;
    repeat (len) @(negedge clk);
    key = 1'b0;
  endtask

  task automatic play(input string pat, input bit glitch);
    for (int i = 0; i < pat.len(); i++) begin
      press((pat[i] == "-") ? 30 : 8);
      if (glitch) begin
        repeat (7) @(negedge clk);
        key = 1'b1;
        repeat (2) @(negedge clk);
        key = 1'b0;
        repeat (5) @(negedge clk);
      end else begin
        repeat (10) @(negedge clk);
      end
    end
  endtask

  task automatic expect_result(input bit valid, input logic [3:0] dig);
    exp_t e;
    e.is_flag = valid;
    e.dig     = dig;
    if (valid || err_en) sb.push_back(e);
  endtask

  task automatic drain(input string name);
    repeat (GAP + 25) @(negedge clk);
    check(name, sb.size(), 0);
    sb.delete();
  endtask

  initial begin
`ifdef MORSE_ERR_EN
    err_en = 1'b1;
`else
    err_en = 1'b0;
`endif
    vecs[0]  = '{".----",  1'b0, 1'b1, 4'd1};
    vecs[1]  = '{"..---",  1'b0, 1'b1, 4'd2};
    vecs[2]  = '{"...--",  1'b0, 1'b1, 4'd3};
    vecs[3]  = '{"....-",  1'b0, 1'b1, 4'd4};
    vecs[4]  = '{"-----",  1'b0, 1'b1, 4'd0};
    vecs[5]  = '{".....",  1'b0, 1'b1, 4'd5};
    vecs[6]  = '{"-....",  1'b0, 1'b1, 4'd6};
    vecs[7]  = '{"---..",  1'b0, 1'b1, 4'd8};
    vecs[8]  = '{"..-",    1'b0, 1'b0, 4'd0};
    vecs[9]  = '{"......", 1'b0, 1'b0, 4'd0};
    vecs[10] = '{"--...",  1'b1, 1'b1, 4'd7};

    repeat (3) @(negedge clk);
    check("reset_digit", digit, 0);
    check("reset_flag", flag, 0);
    check("reset_err", err, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    fork
      forever begin
        exp_t e;
        @(negedge clk);
        cyc++;
        if (rst) begin
          prev_db = 1'b0;
        end else begin
          if (prev_db && !dut.key_db) last_fall = cyc;
          prev_db = dut.key_db;
          check("flag_err_exclusive", {31'd0, flag & err}, 0);
          if (flag || err) begin
            if (sb.size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_pulse actual flag=%0b err=%0b required=none", flag, err);
            end else begin
              e = sb.pop_front();
              check("pulse_kind_flag", flag, e.is_flag);
              if (e.is_flag) begin
                check("digit_on_flag", digit, e.dig);
                model_digit = e.dig;
              end else begin
                check("digit_on_err", digit, model_digit);
              end
              check("pulse_latency", cyc - last_fall, GAP);
            end
          end else begin
            check("digit_hold", digit, model_digit);
          end
        end
      end
    join_none

    for (int v = 0; v < 11; v++) begin
      expect_result(vecs[v].valid, vecs[v].dig);
      play(vecs[v].pat, vecs[v].glitch);
      drain("vector_done");
    end

    // Key held far beyond the dash threshold: no output while held.
    press(150);
    expect_result(1'b0, 4'd0);
    drain("long_press_done");

    // Reset mid-character discards partial symbols.
    play("...", 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    model_digit = 4'd0;
    sb.delete();
    @(negedge clk);
    check("midreset_digit", digit, 0);
    check("midreset_flag", flag, 0);
    check("midreset_err", err, 0);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    drain("post_reset_quiet");
    expect_result(1'b1, 4'd9);
    play("----.", 1'b0);
    drain("after_reset_nine");
    check("final_digit", digit, 9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
